pattern_bit_serializer: RTL and testbench

Upstream feeder for the run-of-ones pattern detectors: accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial line that drives the detector's `x` input. Between words the line idles at a fixed fill level, so any run the detector is tracking is broken unless words are streamed back-to-back. A word-qualifier (`x_valid`) and last-bit marker (`x_last`) are provided for downstream counters and monitors.

---
 rtl/pattern_bit_serializer_if.sv | 27 ++
 rtl/pattern_bit_serializer.sv | 133 +++++++++++++
 tb/tb_pattern_bit_serializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_bit_serializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_bit_serializer_if : word-in / serial-out bundle for the serializer
// Revision 1.0
// ---------------------------------------------------------------------------
interface pattern_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             x_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, x_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, x_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/pattern_bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_bit_serializer : parallel words in, one bit per clock out on x.
// Optional SER_HOLD_EN adds a one-word hold register for gapless streaming.
// Revision 1.0
// ---------------------------------------------------------------------------
module pattern_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FILL      = 1'b0
) (
  input wire clk,
  input wire rst,
  pattern_bit_serializer_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic             x_valid_q;
  logic             x_last_q;
  logic             hold_full;
  logic             xfer;
  logic             last_bit;

  // Vacated positions take FILL, so after a full word the head bit is FILL again.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_d  = {sh_q[WIDTH-2:0], FILL};
      assign bus.x = sh_q[WIDTH-1];
    end else begin : g_lsb_first
      assign sh_d  = {FILL, sh_q[WIDTH-1:1]};
      assign bus.x = sh_q[0];
    end
  endgenerate

  assign cnt_d    = cnt_q + CW'(1);
  assign last_bit = (cnt_q == LAST_CNT);
  assign xfer     = bus.din_valid && bus.din_ready;

`ifdef SER_HOLD_EN
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;

  assign hold_full     = hold_full_q;
  assign bus.din_ready = !rst && !hold_full_q;
`else
  assign hold_full     = 1'b0;
  assign bus.din_ready = !rst && (state_q == S_IDLE);
`endif

  assign bus.x_valid = x_valid_q;
  assign bus.x_last  = x_last_q;
  assign bus.busy    = (state_q == S_SHIFT) || hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= {WIDTH{FILL}};
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
`ifdef SER_HOLD_EN
      hold_q      <= {WIDTH{FILL}};
      hold_full_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            sh_q      <= bus.din;
            cnt_q     <= '0;
            state_q   <= S_SHIFT;
            x_valid_q <= 1'b1;
            x_last_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            cnt_q    <= '0;
            x_last_q <= 1'b0;
`ifdef SER_HOLD_EN
            if (hold_full_q) begin
              sh_q <= hold_q;
              // A word arriving on the same edge refills the hold slot.
              if (xfer) begin
                hold_q <= bus.din;
              end else begin
                hold_full_q <= 1'b0;
              end
            end else if (xfer) begin
              sh_q <= bus.din;
            end else begin
              sh_q      <= sh_d;
              state_q   <= S_IDLE;
              x_valid_q <= 1'b0;
            end
`else
            sh_q      <= sh_d;
            state_q   <= S_IDLE;
            x_valid_q <= 1'b0;
`endif
          end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            x_last_q <= (cnt_d == LAST_CNT);
`ifdef SER_HOLD_EN
            if (xfer) begin
              hold_q      <= bus.din;
              hold_full_q <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pattern_bit_serializer : randomized bench with a queue-based bit model,
// driving an MSB-first and an LSB-first instance with identical stimulus.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pattern_bit_serializer;

`ifdef SER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam bit FILL = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;

  pattern_bit_serializer_if #(.WIDTH(8)) if_m ();
  pattern_bit_serializer_if #(.WIDTH(8)) if_l ();

  assign if_m.din       = din;
  assign if_m.din_valid = din_valid;
  assign if_l.din       = din;
  assign if_l.din_valid = din_valid;

  pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL(FILL)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m)
  );

  pattern_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(FILL)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;
  int acc_cyc[$];

  // Reference model: remaining bits of the word on the line, plus pending words.
  bit         bq_m[$];
  bit         bq_l[$];
  logic [7:0] hq[$];

  logic       exp_ready;
  logic [4:0] exp_m, exp_l, obs_m, obs_l;

  task automatic load(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      bq_m.push_back(w[7-i]);
      bq_l.push_back(w[i]);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    din_valid = v;
    din = d;
    #1;
    exp_ready = !r && (HOLD ? (hq.size() == 0) : (bq_m.size() == 0));
    exp_m = {exp_ready, (bq_m.size() > 0) ? bq_m[0] : FILL, bq_m.size() > 0,
             bq_m.size() == 1, (bq_m.size() > 0) || (hq.size() > 0)};
    exp_l = {exp_ready, (bq_l.size() > 0) ? bq_l[0] : FILL, bq_l.size() > 0,
             bq_l.size() == 1, (bq_l.size() > 0) || (hq.size() > 0)};
    obs_m = {if_m.din_ready, if_m.x, if_m.x_valid, if_m.x_last, if_m.busy};
    obs_l = {if_l.din_ready, if_l.x, if_l.x_valid, if_l.x_last, if_l.busy};
  endtask

  task automatic tick();
    bit xfer;
    @(posedge clk);
    cyc++;
    xfer = din_valid && exp_ready;
    if (rst) begin
      bq_m.delete();
      bq_l.delete();
      hq.delete();
    end else begin
      if (bq_m.size() > 0) begin
        void'(bq_m.pop_front());
        void'(bq_l.pop_front());
      end
      if (bq_m.size() == 0) begin
        if (hq.size() > 0) begin
          load(hq.pop_front());
          if (xfer) hq.push_back(din);
        end else if (xfer) begin
          load(din);
        end
      end else if (xfer) begin
        hq.push_back(din);
      end
      if (xfer) begin
        n_acc++;
        acc_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'hA5);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL reset_msb cyc=%0d got=%b exp=%b", cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL reset_lsb cyc=%0d got=%b exp=%b", cyc, obs_l, exp_l); end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (obs_m !== 5'b10000) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs_m, 5'b10000); end
    tick();
  endtask

  task automatic test_single(input logic [7:0] w);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, i == 0, (i == 0) ? w : 8'($urandom));
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL single_msb w=%h cyc=%0d got=%b exp=%b", w, cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL single_lsb w=%h cyc=%0d got=%b exp=%b", w, cyc, obs_l, exp_l); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int start, run, maxrun, ones;
    start = n_acc;
    run = 0; maxrun = 0; ones = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, (n_acc - start) < 2, 8'hFF);
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL b2b_msb cyc=%0d got=%b exp=%b", cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL b2b_lsb cyc=%0d got=%b exp=%b", cyc, obs_l, exp_l); end
      run = (if_m.x === 1'b1 && if_m.x_valid === 1'b1) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (if_m.x === 1'b1) ones++;
      tick();
    end
    total++;
    if (maxrun != (HOLD ? 16 : 8)) begin bad++; $display("FAIL b2b_run got=%0d exp=%0d", maxrun, HOLD ? 16 : 8); end
    total++;
    if (ones != 16) begin bad++; $display("FAIL b2b_ones got=%0d exp=16", ones); end
  endtask

  task automatic test_hold_full();
    int base, c0;
    base = acc_cyc.size();
    for (int i = 0; i < 34; i++) begin
      drive(1'b0, (acc_cyc.size() - base) < 3, 8'($urandom));
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL holdfull_msb cyc=%0d got=%b exp=%b", cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL holdfull_lsb cyc=%0d got=%b exp=%b", cyc, obs_l, exp_l); end
      tick();
    end
    total++;
    if (acc_cyc.size() - base != 3) begin
      bad++; $display("FAIL holdfull_count got=%0d exp=3", acc_cyc.size() - base);
    end else begin
      c0 = acc_cyc[base];
      total++;
      if (acc_cyc[base+2] - c0 != (HOLD ? 9 : 18)) begin
        bad++; $display("FAIL holdfull_third got=%0d exp=%0d", acc_cyc[base+2] - c0, HOLD ? 9 : 18);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      drive(i == 5, (i < 2) || (i == 7), (i == 0) ? 8'hAA : 8'($urandom));
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL rstmid_msb cyc=%0d got=%b exp=%b", cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL rstmid_lsb cyc=%0d got=%b exp=%b", cyc, obs_l, exp_l); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      total++;
      if (obs_m !== exp_m) begin bad++; $display("FAIL random_msb cyc=%0d got=%b exp=%b", cyc, obs_m, exp_m); end
      total++;
      if (obs_l !== exp_l) begin bad++; $display("FAIL random_lsb cyc=%0d got=%b exp=%b", cyc, obs_l, exp_l); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hFC);
    test_single(8'h3F);
    test_back_to_back();
    test_single(8'h00);
    test_hold_full();
    test_single(8'h81);
    test_reset_mid();
    test_random();
    test_single(8'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
